acc_seq_ctrl: RTL and testbench
===============================

// Module: acc_seq_ctrl
// PURPOSE
//  Host-facing sequencer for the CNN accelerator RAMs (4 image banks, conv RAM, dense RAM).
//  Decodes Avalon-MM slave writes into RAM write strobes with auto-incrementing pointers.
//  Unpacks 32-bit words into byte writes for the conv and dense RAMs.
//  On START, sweeps the read addresses for the compute datapath and reports completion.
// PARAMETERS
//  IMG_AW  10  image bank address width (depth 2**IMG_AW)
//  PAR_AW  15  conv/dense RAM address width
//  RD_LAT  2   RAM read latency in cycles (address to data valid), >=1
// PORTS
//  clk          in   1       system clock; all logic on its rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  chipselect   in   1       Avalon slave select
//  write        in   1       Avalon write strobe
//  read         in   1       Avalon read strobe
//  address      in   3       register index
//  writedata    in   32      write data
//  readdata     out  32      read data; combinational from address
//  waitrequest  out  1       stall; host holds its access while this is high
//  img_we       out  4       per-bank write strobe; bit k writes img_wdata[8k+7:8k] to bank k
//  img_wdata    out  32      image write data
//  img_waddr    out  IMG_AW  image write address
//  conv_we      out  1       conv RAM byte write strobe
//  dense_we     out  1       dense RAM byte write strobe
//  par_wdata    out  8       conv/dense write byte
//  par_waddr    out  PAR_AW  conv/dense write address
//  img_raddr    out  IMG_AW  image read address (compute sweep)
//  par_raddr    out  PAR_AW  conv/dense read address (compute sweep)
//  rd_valid     out  1       RAM read data valid this cycle
//  rd_last      out  1       rd_valid for the final sweep address
//  busy         out  1       state != IDLE
//  irq          out  1       completion interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Registers:
//   0 CTRL (W): [1:0] target (0 img, 1 conv, 2 dense, 3 none); [2] ptr_clr; [3] start; [30:16] run_len-1
//   1 DATA (W): stream word to the selected target
//   2 STATUS (R): [0] busy; [1] done; [2] ovf; [31:16] load pointer, zero-extended
//   Other addresses: writes ignored, reads return 0.
//  Reset: all outputs 0; state IDLE; pointers 0; target 3; done=ovf=0.
//  FSM states IDLE, SER, RUN, DRAIN:
//   IDLE + DATA write, target img: at T+1, img_we=4'hF, img_waddr=ptr; ptr+1. Stays IDLE.
//   IDLE + DATA write, target conv/dense -> SER: bytes LSB-first at T+1..T+4 on
//    consecutive par_waddr values; ptr+1 per byte; back to IDLE after byte 3.
//   IDLE + CTRL start=1 -> RUN next cycle: raddr=0,1,...,run_len-1, one per cycle;
//    img_raddr = count[IMG_AW-1:0] (wraps).
//   RUN -> DRAIN after the last address; DRAIN lasts RD_LAT cycles, then IDLE with done=1.
//   rd_valid = address-issue qualifier delayed RD_LAT cycles; rd_last marks the final one.
//  CTRL write fields: target and ptr_clr apply in the same cycle; ptr_clr zeroes the
//   selected pointer and ovf. One load pointer per target.
//  waitrequest = chipselect & write & (state != IDLE). Reads never stall.
//  STATUS read clears done (and irq). A clear in the same cycle as a new done: done wins.
//  Pointer wrap (img at 2**IMG_AW-1, par at 2**PAR_AW-1): wraps to 0 and sets sticky ovf.
//  DATA write with target 3: accepted and dropped.
//  start with run_len field 0: sweep of 1 address.
//  reset_n low mid-SER or mid-RUN: strobes drop immediately; the partial word is lost.
// CONFIGURATION
//  ACC_SEQ_IRQ_EN defined: irq=1 from the cycle done sets until the STATUS read that clears it.
//  ACC_SEQ_IRQ_EN undefined: irq tied 0; done is visible only by polling.
// TESTING
//  After reset: CTRL=0x0 (img), DATA=0x44332211 -> next cycle img_we=F, img_waddr=0,
//   img_wdata=0x44332211; STATUS[31:16]=1.
//  CTRL=0x1 (conv), DATA=0xDDCCBBAA -> conv_we for 4 cycles: bytes AA,BB,CC,DD at
//   par_waddr 0..3; a second DATA write during this sees waitrequest=1 for 3 cycles.
//  CTRL=0x00040008 (start, run_len=5) with RD_LAT=2 -> raddr 0..4, rd_valid on 5
//   consecutive cycles 2 later, rd_last on the 5th; done=1 and irq=1 (with EN).
//  Read STATUS after done -> readdata[1]=1; next read [1]=0; irq=0.
//  IMG_AW=2: 5 image DATA writes -> 5th lands at img_waddr 0; ovf=1; CTRL=0x4 clears ovf.
//  reset_n low 2 cycles into RUN -> busy, rd_valid, img_we=0 asynchronously; STATUS=0 afterwards.

Source files
------------

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: host-facing sequencer for the CNN accelerator RAMs.
// Turns Avalon-MM slave writes into image/conv/dense RAM write strobes with
// per-target auto-incrementing load pointers, serialises 32-bit words into
// byte writes for the conv/dense RAMs, and on START sweeps the compute read
// addresses, tracking RAM read latency to flag valid and last read data.
// Optional build macro: ACC_SEQ_IRQ_EN drives irq from the done flag; when it
// is undefined irq is tied low and completion is visible only by polling.
module acc_seq_ctrl #(
    parameter int IMG_AW = 10,
    parameter int PAR_AW = 15,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [3:0]        img_we,
    output logic [31:0]       img_wdata,
    output logic [IMG_AW-1:0] img_waddr,
    output logic              conv_we,
    output logic              dense_we,
    output logic [7:0]        par_wdata,
    output logic [PAR_AW-1:0] par_waddr,
    output logic [IMG_AW-1:0] img_raddr,
    output logic [PAR_AW-1:0] par_raddr,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              busy,
    output logic              irq
);

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_DATA  = 3'd1;
    localparam logic [2:0] A_STAT  = 3'd2;

    localparam logic [1:0] T_IMG   = 2'd0;
    localparam logic [1:0] T_CONV  = 2'd1;
    localparam logic [1:0] T_DENSE = 2'd2;
    localparam logic [1:0] T_NONE  = 2'd3;

    // Drain counter only has to reach RD_LAT-1.
    localparam int               DRN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SER   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Load side
    logic [1:0]         r_tgt;
    logic [IMG_AW-1:0]  r_img_ptr;
    logic [PAR_AW-1:0]  r_conv_ptr;
    logic [PAR_AW-1:0]  r_dense_ptr;
    logic               r_ovf;
    logic [3:0]         r_img_we;
    logic [31:0]        r_img_wdata;
    logic [IMG_AW-1:0]  r_img_waddr;
    logic               r_conv_we;
    logic               r_dense_we;
    logic [7:0]         r_par_wdata;
    logic [PAR_AW-1:0]  r_par_waddr;
    logic [31:0]        r_word;
    logic [1:0]         r_byte;

    // Sweep side
    logic [14:0]        r_cnt;
    logic [14:0]        r_len;
    logic [DRN_W-1:0]   r_drn;
    logic [RD_LAT-1:0]  r_vld_sr;
    logic [RD_LAT-1:0]  r_last_sr;
    logic               r_done;

    logic               w_acc;
    logic               w_ctrl_wr;
    logic               w_data_wr;
    logic               w_stat_rd;
    logic               w_start;
    logic               w_par_tgt;
    logic               w_busy;
    logic               w_issue;
    logic               w_issue_last;
    logic               w_drain_end;
    logic               w_par_emit;
    logic [7:0]         w_par_byte;
    logic [PAR_AW-1:0]  w_par_ptr;
    logic [15:0]        w_ptr16;
    logic               w_unused;

    // Host access decode: writes are only accepted while idle.
    assign w_busy      = (r_state != S_IDLE);
    assign waitrequest = chipselect & write & w_busy;
    assign w_acc       = chipselect & write & ~w_busy;
    assign w_ctrl_wr   = w_acc & (address == A_CTRL);
    assign w_data_wr   = w_acc & (address == A_DATA);
    assign w_stat_rd   = chipselect & read & (address == A_STAT);
    assign w_start     = w_ctrl_wr & writedata[3];
    assign w_par_tgt   = (r_tgt == T_CONV) || (r_tgt == T_DENSE);
    assign w_unused    = &{1'b0, writedata[31], writedata[15:4]};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and sweep qualifiers.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        w_drain_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end else if (w_data_wr && w_par_tgt) begin
                    w_state_nxt = S_SER;
                end
            end
            S_SER: begin
                if (r_byte == 2'd3) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_issue = 1'b1;
                if (r_cnt == r_len) begin
                    w_issue_last = 1'b1;
                    w_state_nxt  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drn == DRN_LAST) begin
                    w_drain_end = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte serialiser selection: byte 0 straight from the bus, then the held word.
    always_comb begin
        w_par_emit = (w_data_wr && w_par_tgt) || (r_state == S_SER);
        w_par_byte = writedata[7:0];
        if (r_state == S_SER) begin
            case (r_byte)
                2'd1:    w_par_byte = r_word[15:8];
                2'd2:    w_par_byte = r_word[23:16];
                2'd3:    w_par_byte = r_word[31:24];
                default: w_par_byte = r_word[7:0];
            endcase
        end
        w_par_ptr = (r_tgt == T_DENSE) ? r_dense_ptr : r_conv_ptr;
    end

    // Load pointers, write strobes and write data/address registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tgt       <= T_NONE;
            r_img_ptr   <= '0;
            r_conv_ptr  <= '0;
            r_dense_ptr <= '0;
            r_ovf       <= 1'b0;
            r_img_we    <= '0;
            r_img_wdata <= '0;
            r_img_waddr <= '0;
            r_conv_we   <= 1'b0;
            r_dense_we  <= 1'b0;
            r_par_wdata <= '0;
            r_par_waddr <= '0;
            r_word      <= '0;
            r_byte      <= '0;
        end else begin
            r_img_we   <= '0;
            r_conv_we  <= 1'b0;
            r_dense_we <= 1'b0;

            if (w_ctrl_wr) begin
                r_tgt <= writedata[1:0];
                if (writedata[2]) begin
                    r_ovf <= 1'b0;
                    case (writedata[1:0])
                        T_IMG:   r_img_ptr   <= '0;
                        T_CONV:  r_conv_ptr  <= '0;
                        T_DENSE: r_dense_ptr <= '0;
                        default: ;
                    endcase
                end
            end

            if (w_data_wr && (r_tgt == T_IMG)) begin
                r_img_we    <= 4'hF;
                r_img_wdata <= writedata;
                r_img_waddr <= r_img_ptr;
                r_img_ptr   <= r_img_ptr + 1'b1;
                if (&r_img_ptr) begin
                    r_ovf <= 1'b1;
                end
            end

            if (w_data_wr && w_par_tgt) begin
                r_word <= writedata;
                r_byte <= 2'd1;
            end else if (r_state == S_SER) begin
                r_byte <= r_byte + 2'd1;
            end

            if (w_par_emit) begin
                r_conv_we   <= (r_tgt == T_CONV);
                r_dense_we  <= (r_tgt == T_DENSE);
                r_par_wdata <= w_par_byte;
                r_par_waddr <= w_par_ptr;
                if (r_tgt == T_DENSE) begin
                    r_dense_ptr <= r_dense_ptr + 1'b1;
                end else begin
                    r_conv_ptr  <= r_conv_ptr + 1'b1;
                end
                if (&w_par_ptr) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Read sweep counter, drain timer, read-latency pipes and done flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_len     <= '0;
            r_drn     <= '0;
            r_vld_sr  <= '0;
            r_last_sr <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
                r_len <= writedata[30:16];
            end else if (w_issue && !w_issue_last) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == S_DRAIN) begin
                r_drn <= r_drn + 1'b1;
            end else begin
                r_drn <= '0;
            end

            // issue -> RAM data valid, RD_LAT cycles later
            r_vld_sr[0]  <= w_issue;
            r_last_sr[0] <= w_issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i]  <= r_vld_sr[i-1];
                r_last_sr[i] <= r_last_sr[i-1];
            end

            // a new completion beats a simultaneous STATUS-read clear
            if (w_drain_end) begin
                r_done <= 1'b1;
            end else if (w_stat_rd) begin
                r_done <= 1'b0;
            end
        end
    end

    // STATUS readback; the load pointer shown is that of the current target.
    always_comb begin
        w_ptr16 = '0;
        case (r_tgt)
            T_IMG:   w_ptr16[IMG_AW-1:0] = r_img_ptr;
            T_CONV:  w_ptr16[PAR_AW-1:0] = r_conv_ptr;
            T_DENSE: w_ptr16[PAR_AW-1:0] = r_dense_ptr;
            default: w_ptr16 = '0;
        endcase
        readdata = '0;
        if (address == A_STAT) begin
            readdata = {w_ptr16, 13'd0, r_ovf, r_done, w_busy};
        end
    end

    assign img_we    = r_img_we;
    assign img_wdata = r_img_wdata;
    assign img_waddr = r_img_waddr;
    assign conv_we   = r_conv_we;
    assign dense_we  = r_dense_we;
    assign par_wdata = r_par_wdata;
    assign par_waddr = r_par_waddr;
    assign img_raddr = r_cnt[IMG_AW-1:0];
    assign par_raddr = r_cnt[PAR_AW-1:0];
    assign rd_valid  = r_vld_sr[RD_LAT-1];
    assign rd_last   = r_last_sr[RD_LAT-1];
    assign busy      = w_busy;

`ifdef ACC_SEQ_IRQ_EN
    assign irq = r_done;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb_acc_seq_ctrl: directed-vector bench for acc_seq_ctrl (IMG_AW=2 so the
// image pointer wrap is reachable, PAR_AW=15, RD_LAT=2).
module tb_acc_seq_ctrl;

    localparam int IMG_AW = 2;
    localparam int PAR_AW = 15;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              reset_n;
    logic              chipselect;
    logic              write;
    logic              read;
    logic [2:0]        address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic [3:0]        img_we;
    logic [31:0]       img_wdata;
    logic [IMG_AW-1:0] img_waddr;
    logic              conv_we;
    logic              dense_we;
    logic [7:0]        par_wdata;
    logic [PAR_AW-1:0] par_waddr;
    logic [IMG_AW-1:0] img_raddr;
    logic [PAR_AW-1:0] par_raddr;
    logic              rd_valid;
    logic              rd_last;
    logic              busy;
    logic              irq;

    int n_vec;
    int n_err;

    acc_seq_ctrl #(
        .IMG_AW (IMG_AW),
        .PAR_AW (PAR_AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .img_we      (img_we),
        .img_wdata   (img_wdata),
        .img_waddr   (img_waddr),
        .conv_we     (conv_we),
        .dense_we    (dense_we),
        .par_wdata   (par_wdata),
        .par_waddr   (par_waddr),
        .img_raddr   (img_raddr),
        .par_raddr   (par_raddr),
        .rd_valid    (rd_valid),
        .rd_last     (rd_last),
        .busy        (busy),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle host write; returns 1ns after the accepting edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    // Combinational read of a register (no clock edge consumed).
    task automatic rd_peek(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        #1;
        d = readdata;
    endtask

    task automatic rd_end();
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    logic [31:0] v;
    logic [7:0]  conv_bytes [4];
    logic        irq_on;

    initial begin
        n_vec      = 0;
        n_err      = 0;
`ifdef ACC_SEQ_IRQ_EN
        irq_on     = 1'b1;
`else
        irq_on     = 1'b0;
`endif
        conv_bytes[0] = 8'hAA;
        conv_bytes[1] = 8'hBB;
        conv_bytes[2] = 8'hCC;
        conv_bytes[3] = 8'hDD;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = '0;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_img_we", 32'(img_we), 32'd0);
        chk("rst_conv",   32'(conv_we), 32'd0);
        chk("rst_valid",  32'(rd_valid), 32'd0);
        chk("rst_irq",    32'(irq), 32'd0);
        rd_peek(3'd2, v);
        chk("rst_status", v, 32'h0000_0000);
        chk("rst_wait",   32'(waitrequest), 32'd0);
        rd_end();

        // Image word write
        wr(3'd0, 32'h0000_0000);
        wr(3'd1, 32'h4433_2211);
        chk("img_we",    32'(img_we), 32'hF);
        chk("img_waddr", 32'(img_waddr), 32'd0);
        chk("img_wdata", img_wdata, 32'h4433_2211);
        rd_peek(3'd2, v);
        chk("img_ptr1",  v, 32'h0001_0000);
        rd_peek(3'd3, v);
        chk("rd_other",  v, 32'h0);
        rd_end();

        // Conv word unpack with a stalled second write
        wr(3'd0, 32'h0000_0001);
        wr(3'd1, 32'hDDCC_BBAA);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 3'd1;
        writedata  = 32'h0403_0201;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("conv_we%0d", k),   32'(conv_we), 32'd1);
            chk($sformatf("conv_byte%0d", k), 32'(par_wdata), 32'(conv_bytes[k]));
            chk($sformatf("conv_addr%0d", k), 32'(par_waddr), 32'(k));
            chk($sformatf("conv_wait%0d", k), 32'(waitrequest), (k < 3) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        chipselect = 1'b0;
        write      = 1'b0;
        chk("conv2_byte0", 32'(par_wdata), 32'h01);
        chk("conv2_addr0", 32'(par_waddr), 32'd4);
        chk("conv2_dense", 32'(dense_we), 32'd0);
        repeat (4) tick();
        chk("conv_idle",   32'(busy), 32'd0);

        // Compute sweep: run_len=5
        wr(3'd0, 32'h0004_0008);
        for (int c = 0; c < 8; c++) begin
            if (c < 5) begin
                chk($sformatf("par_raddr%0d", c), 32'(par_raddr), 32'(c));
                chk($sformatf("img_raddr%0d", c), 32'(img_raddr), 32'(c % 4));
            end
            chk($sformatf("rd_valid%0d", c), 32'(rd_valid), (c >= 2 && c <= 6) ? 32'd1 : 32'd0);
            chk($sformatf("rd_last%0d", c),  32'(rd_last), (c == 6) ? 32'd1 : 32'd0);
            chk($sformatf("busy%0d", c),     32'(busy), (c <= 6) ? 32'd1 : 32'd0);
            tick();
        end
        chk("run_irq",   32'(irq), 32'(irq_on));
        rd_peek(3'd2, v);
        chk("done_set",  32'(v[1]), 32'd1);
        rd_end();
        rd_peek(3'd2, v);
        chk("done_clr",  32'(v[1]), 32'd0);
        chk("irq_clr",   32'(irq), 32'd0);
        rd_end();

        // Sweep with run_len field 0: a single address
        wr(3'd0, 32'h0000_0008);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("one_valid%0d", c), 32'(rd_valid), (c == 2) ? 32'd1 : 32'd0);
            chk($sformatf("one_last%0d", c),  32'(rd_last), (c == 2) ? 32'd1 : 32'd0);
            chk($sformatf("one_busy%0d", c),  32'(busy), (c <= 2) ? 32'd1 : 32'd0);
            tick();
        end
        rd_peek(3'd2, v);
        chk("one_done",  32'(v[1]), 32'd1);
        rd_end();

        // Image pointer wrap and sticky overflow
        wr(3'd0, 32'h0000_0004);
        for (int i = 0; i < 5; i++) begin
            wr(3'd1, 32'(i + 16));
        end
        chk("wrap_waddr", 32'(img_waddr), 32'd0);
        chk("wrap_wdata", img_wdata, 32'd20);
        rd_peek(3'd2, v);
        chk("wrap_ovf",   v, 32'h0001_0004);
        rd_end();
        wr(3'd0, 32'h0000_0004);
        rd_peek(3'd2, v);
        chk("ovf_clr",    v, 32'h0000_0000);
        rd_end();

        // DATA with target 3 is dropped
        wr(3'd0, 32'h0000_0003);
        wr(3'd1, 32'h5555_5555);
        chk("drop_img",   32'(img_we), 32'd0);
        chk("drop_conv",  32'(conv_we), 32'd0);
        chk("drop_dense", 32'(dense_we), 32'd0);
        chk("drop_busy",  32'(busy), 32'd0);

        // Dense uses its own pointer
        wr(3'd0, 32'h0000_0002);
        wr(3'd1, 32'h0000_00EE);
        chk("dense_we",   32'(dense_we), 32'd1);
        chk("dense_conv", 32'(conv_we), 32'd0);
        chk("dense_byte", 32'(par_wdata), 32'hEE);
        chk("dense_addr", 32'(par_waddr), 32'd0);
        repeat (4) tick();

        // Asynchronous reset two cycles into a sweep
        wr(3'd0, 32'h0004_0008);
        tick();
        tick();
        chk("pre_rst_valid", 32'(rd_valid), 32'd1);
        chk("pre_rst_busy",  32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_img",   32'(img_we), 32'd0);
        #3 reset_n = 1'b1;
        tick();
        rd_peek(3'd2, v);
        chk("arst_status", v, 32'h0000_0000);
        rd_end();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
